// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add integer multiplier covering the RISC-V M-extension
// multiply ops (MUL, MULH, MULHSU, MULHU). Each CALC clock retires BPC multiplier bits.
// The latency is fixed at ITER = XLEN/BPC edges from accept to out_valid.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   request handshake; in_op, in_a, in_b, in_tag are taken on accept
//   out_valid/out_ready result handshake; out_result, out_tag are held while out_valid is high
//   busy                high while an operation is in CALC or DONE
//
// Handshake semantics (both sides): a transfer happens on a rising edge where valid and
// ready are both high. The producer holds valid and its payload stable until that edge.
// ready may depend on state only and never on valid.
module mult_seq #(
  parameter int XLEN  = 32,
  parameter int BPC   = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int ITER = XLEN / BPC;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  if (XLEN < 4 || (XLEN % BPC) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_param_check
    $error("mult_seq: illegal XLEN/BPC combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exposed for checkers bound onto this module.
  state_t state;
  state_t state_nxt;

  logic [1:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_q;
  logic [2*XLEN-1:0] mcand_q;   // |a|, shifted left BPC bits per step
  logic [XLEN:0]     mplier_q;  // |b|, shifted right BPC bits per step
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;

  logic              last_step;

  // Operand decode: extend each operand to XLEN+1 bits, so that the most negative
  // value has a representable magnitude.
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN:0]     a_ext, b_ext, mag_a, mag_b;

  always_comb begin
    a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    b_signed = (in_op == OP_MULH);
    a_neg    = a_signed & in_a[XLEN-1];
    b_neg    = b_signed & in_b[XLEN-1];
    a_ext    = {a_neg, in_a};
    b_ext    = {b_neg, in_b};
    mag_a    = a_neg ? -a_ext : a_ext;
    mag_b    = b_neg ? -b_ext : b_ext;
  end

  // One shift-add step. The arithmetic is modulo 2^(2*XLEN). Bits that shift out of
  // mcand_q fall only above the true product, so they never affect the result.
  logic [BPC-1:0]    digit;
  logic [2*XLEN-1:0] partial, acc_sum, prod_fin;

  always_comb begin
    digit    = mplier_q[BPC-1:0];
    partial  = mcand_q * {{(2*XLEN-BPC){1'b0}}, digit};
    acc_sum  = acc_q + partial;
    prod_fin = neg_q ? -acc_sum : acc_sum;
  end

  assign last_step = (cnt_q == CW'(ITER - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == CALC) || (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      tag_q      <= '0;
      neg_q      <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            tag_q    <= in_tag;
            neg_q    <= a_neg ^ b_neg;
            mcand_q  <= {{(XLEN-1){1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << BPC;
          mplier_q <= mplier_q >> BPC;
          cnt_q    <= cnt_q + CW'(1);
          if (last_step) begin
            out_result <= (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
            out_tag    <= tag_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Testbench for mult_seq. It runs three instances (BPC = 1, 4, 2) at XLEN = 32,
// exercising one instance at a time. A table of directed vectors, a backpressure
// sequence and a reset-abort sequence run on the BPC=1 instance. The random
// operations are checked against a 64-bit golden model on the BPC=4 and BPC=2 instances.
module tb_mult_seq;

  localparam int W = 2 + 5 + 32;  // {dut index, tag, result}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [3];
  logic        in_valid   [3];
  logic        in_ready   [3];
  logic [1:0]  in_op      [3];
  logic [31:0] in_a       [3];
  logic [31:0] in_b       [3];
  logic [4:0]  in_tag     [3];
  logic        out_valid  [3];
  logic        out_ready  [3];
  logic [31:0] out_result [3];
  logic [4:0]  out_tag    [3];
  logic        busy       [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mult_seq #(
      .XLEN (32),
      .BPC  (g == 0 ? 1 : (g == 1 ? 4 : 2)),
      .TAG_W(5)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_op     (in_op[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .in_tag    (in_tag[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_result(out_result[g]),
      .out_tag   (out_tag[g]),
      .busy      (busy[g])
    );
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_edge [3];
  logic prev_ov [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iter_of(int d);
    return (d == 0) ? 32 : ((d == 1) ? 8 : 16);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Golden model: multiply the sign- or zero-extended 64-bit operands modulo 2^64.
  function automatic logic [31:0] golden(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: samples on the falling edge, which is half a cycle away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n[d]) begin
        prev_ov[d] <= 1'b0;
      end else begin
        if (in_valid[d] && in_ready[d]) acc_edge[d] <= cyc + 1;
        if (out_valid[d] && !prev_ov[d])
          check($sformatf("latency_d%0d", d), 64'(cyc - acc_edge[d]), 64'(iter_of(d)));
        if (out_valid[d] && out_ready[d]) begin
          check($sformatf("out_queue_d%0d", d), 64'(exp_q.size()), 64'd1);
          if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check($sformatf("result_d%0d", d), 64'(out_result[d]), 64'(e[31:0]));
            check($sformatf("tag_d%0d", d), 64'(out_tag[d]), 64'(e[36:32]));
            check("dut_index", 64'(d), 64'(e[38:37]));
          end
        end
        prev_ov[d] <= out_valid[d];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // The caller enters just after a rising edge. The task returns just after the accept edge.
  task automatic issue(int d, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       logic [4:0] tag, logic [31:0] exp);
    int n = 0;
    in_op[d]    = op;
    in_a[d]     = a;
    in_b[d]     = b;
    in_tag[d]   = tag;
    in_valid[d] = 1'b1;
    exp_q.push_back({2'(d), tag, exp});
    @(negedge clk);
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(in_ready[d]), 64'd1);
    @(posedge clk);
    #2;
    in_valid[d] = 1'b0;
    // Scramble the request ports after accept; the operation in flight must not see this.
    in_op[d]  = 2'($urandom_range(0, 3));
    in_a[d]   = $urandom();
    in_b[d]   = $urandom();
    in_tag[d] = 5'($urandom_range(0, 31));
  endtask

  task automatic drain(int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    vecs[0] = '{2'b00, 32'h0000_0004, 32'h0000_0003, 5'd7,  32'h0000_000C};
    vecs[1] = '{2'b00, 32'h0000_0001, 32'h0000_0002, 5'd1,  32'h0000_0002};
    vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
    vecs[4] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE};
    vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h0000_0000};
    vecs[7] = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 5'd8,  32'hC000_0000};
    vecs[8] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd30, 32'h8000_0000};
    vecs[9] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};

    for (int d = 0; d < 3; d++) begin
      rst_n[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      in_op[d]     = 2'b00;
      in_a[d]      = '0;
      in_b[d]      = '0;
      in_tag[d]    = '0;
      out_ready[d] = 1'b1;
      acc_edge[d]  = 0;
    end

    // ---- reset ----
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready",   64'(in_ready[d]),   64'd1);
      check("rst_out_valid",  64'(out_valid[d]),  64'd0);
      check("rst_busy",       64'(busy[d]),       64'd0);
      check("rst_out_result", 64'(out_result[d]), 64'd0);
      check("rst_out_tag",    64'(out_tag[d]),    64'd0);
    end
    @(posedge clk);
    #2;

    // ---- directed table on BPC=1 ----
    for (int i = 0; i < 10; i++) begin
      issue(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);
      drain(100);
    end

    // ---- backpressure: stall in DONE with requests knocking ----
    out_ready[0] = 1'b0;
    issue(0, 2'b00, 32'd9, 32'd9, 5'd3, 32'd81);
    seen = 0;
    while (!out_valid[0] && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    check("bp_reach_done", 64'(out_valid[0]), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      in_valid[0] = (k % 2 == 0);
      in_a[0]     = $urandom();
      in_b[0]     = $urandom();
      in_tag[0]   = 5'($urandom_range(0, 31));
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid[0]),  64'd1);
      check("bp_result",    64'(out_result[0]), 64'd81);
      check("bp_tag",       64'(out_tag[0]),    64'd3);
      check("bp_in_ready",  64'(in_ready[0]),   64'd0);
      check("bp_busy",      64'(busy[0]),       64'd1);
    end
    @(posedge clk);
    #2;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);   // monitor pops the stalled result here
    @(negedge clk);   // one edge after the handshake
    check("bp_idle_in_ready",  64'(in_ready[0]),  64'd1);
    check("bp_idle_out_valid", 64'(out_valid[0]), 64'd0);
    check("bp_idle_busy",      64'(busy[0]),      64'd0);
    check("bp_no_accept",      64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #2;

    // ---- abort by reset mid-CALC ----
    issue(0, 2'b00, 32'd5, 32'd5, 5'd10, 32'd25);
    repeat (9) @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n[0] = 1'b1;
    exp_q.delete();
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    check("abort_busy",     64'(busy[0]), 64'd0);
    @(posedge clk);
    #2;
    issue(0, 2'b00, 32'd6, 32'd7, 5'd9, 32'h0000_002A);
    drain(100);

    // ---- random on BPC=4 and BPC=2 ----
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [1:0]  op;
        logic [31:0] a, b;
        op = 2'($urandom_range(0, 3));
        a  = pick();
        b  = pick();
        issue(d, op, a, b, 5'($urandom_range(0, 31)), golden(op, a, b));
        drain(60);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
